gamepad_move_cmd: RTL
=====================

# gamepad_move_cmd

Converts the per-button level outputs of the single-controller gamepad decoder into a stream of discrete move commands for the 2048 game engine. It debounces each button, issues one command per press, and auto-repeats a held direction. Commands are buffered in a 2-entry FIFO behind a valid/ready handshake. It also produces a one-cycle restart pulse for the start+select combination. It sits directly downstream of the gamepad decoder and upstream of the board-update logic.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive cycles a raw level must differ from the filtered level before the filtered level flips (≥2).
- REPEAT_DELAY, 12_500_000: cycles from a command to the first auto-repeat (500 ms @ 25 MHz).
- REPEAT_PERIOD, 5_000_000: cycles between subsequent auto-repeats (200 ms @ 25 MHz).
- CNT_W, 24: width of the repeat counter. Must hold both REPEAT_DELAY and REPEAT_PERIOD.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- btn_up, btn_down, btn_left, btn_right  in  1 each  raw button levels, already in the clk domain.
- btn_start, btn_select  in  1 each  raw button levels.
- is_present  in  1  controller connected.
- cmd_valid  out  1  FIFO head holds a command.
- cmd_dir  out  2  head command: 00 up, 01 down, 10 left, 11 right.
- cmd_ready  in  1  consumer accepts the head this cycle.
- restart  out  1  one-cycle pulse requesting a new game.
- cmd_overflow  out  1  one-cycle pulse when a command is dropped because the FIFO is full.

## Operation
- **Reset state.** All outputs are 0. The FIFO is empty, the FSM is in IDLE, all filtered levels and debounce counters are 0, and the repeat counter is 0.
- **Debounce** (six buttons, independent):
  - When raw ≠ filtered, the counter increments. When raw = filtered, the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES, filtered takes the raw value and the counter clears.
- **Controller absent** (is_present=0):
  - All filtered levels and counters clear immediately, the FIFO empties, and the FSM goes to IDLE.
  - No command, restart or overflow is produced.
- **Direction select.**
  - dir_act is high when exactly one filtered direction is high; dir_sel is that direction's code.
  - Zero, two or more directions held means no active direction. Diagonals are ignored.
- **FSM states: IDLE, HOLD, REPEAT.**
  - **IDLE:** when dir_act is high, push dir_sel, load the counter with REPEAT_DELAY, and go to HOLD.
  - **HOLD / REPEAT, direction released** (dir_act=0): go to IDLE with no push.
  - **HOLD / REPEAT, direction changed** (dir_sel differs from the latched direction): push the new direction, latch it, load REPEAT_DELAY, and go to HOLD.
  - **HOLD / REPEAT, otherwise:** decrement the counter. In the cycle the counter equals 1, push the latched direction, load REPEAT_PERIOD, and go to REPEAT.
- **Restart.**
  - On a rising edge of (filtered start & filtered select), assert restart for one cycle and flush the FIFO.
  - If a push and a restart occur in the same cycle, the restart wins and the push is discarded.
- **FIFO** (depth 2):
  - cmd_valid = not empty; cmd_dir = head entry.
  - A pop occurs when cmd_valid & cmd_ready.
  - Push plus pop when full: both happen and the FIFO stays full.
  - Push when full with no pop: the new command is dropped and cmd_overflow pulses.
  - Push when empty: the entry is visible the next cycle. There is no same-cycle bypass.

## Timing
- **Press latency.** Raw level first sampled high at edge E0 → filtered high after E0+DEBOUNCE_CYCLES−1 → push at E0+DEBOUNCE_CYCLES → cmd_valid high in the following cycle.
- **First repeat.** The push occurs exactly REPEAT_DELAY edges after the initial push.
- **Later repeats.** Each occurs exactly REPEAT_PERIOD edges after the previous one.
- **Handshake.** While cmd_valid & !cmd_ready, cmd_dir and cmd_valid hold stable. cmd_ready is ignored while cmd_valid=0.
- **Pulse outputs.** restart and cmd_overflow are registered and asserted high for exactly one cycle per event.
- **Reset mid-operation.** All state returns to reset values at the next edge. Queued commands are lost.

## Test plan
- **Single press.** DEBOUNCE_CYCLES=4, cmd_ready=1. btn_left high for 20 cycles → exactly one command, cmd_dir=10, cmd_valid high 1 cycle, 5 edges after the first high sample.
- **Glitch rejection.** btn_up high for 3 cycles then low → no command. cmd_valid stays 0.
- **Auto-repeat.** REPEAT_DELAY=10, REPEAT_PERIOD=4. btn_right held for 30 cycles → pushes at t0, t0+10, t0+14, t0+18, …. Release → no further pushes.
- **Full FIFO and overflow.** cmd_ready=0, three distinct presses (up, down, left) → FIFO holds 00 then 01, one cmd_overflow pulse. cmd_ready=1 → dir 00 then 01 popped on consecutive cycles.
- **Diagonal and direction change.** up+left held → no command. Release left → up pushed. Change up→down (after debounce) → down pushed immediately and the delay restarts.
- **Restart and removal.** select held, then start pressed with 1 command queued → restart pulses once and cmd_valid drops. is_present=0 mid-hold → FSM IDLE, FIFO empty, no repeats.

Source files
------------

// File: rtl/gamepad_move_cmd.sv
// Turns debounced gamepad button levels into a queue of 2048 move commands,
// with auto-repeat on a held direction and a start+select restart pulse.
module gamepad_move_cmd #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 12_500_000,
    parameter int REPEAT_PERIOD   = 5_000_000,
    parameter int CNT_W           = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_start,
    input  logic       btn_select,
    input  logic       is_present,
    output logic       cmd_valid,
    output logic [1:0] cmd_dir,
    input  logic       cmd_ready,
    output logic       restart,
    output logic       cmd_overflow
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    logic       clear;
    logic [5:0] raw;
    logic [5:0] filt;

    assign clear = !rst_n || !is_present;
    assign raw   = {btn_select, btn_start, btn_right, btn_left, btn_down, btn_up};

    // Filtered level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_db
            logic            filt_reg;
            logic [DB_W-1:0] db_cnt_reg;

            always_ff @(posedge clk) begin
                if (clear) begin
                    filt_reg   <= 1'b0;
                    db_cnt_reg <= '0;
                end else if (raw[gi] == filt_reg) begin
                    db_cnt_reg <= '0;
                end else if (db_cnt_reg == DB_LAST) begin
                    filt_reg   <= raw[gi];
                    db_cnt_reg <= '0;
                end else begin
                    db_cnt_reg <= db_cnt_reg + 1'b1;
                end
            end

            assign filt[gi] = filt_reg;
        end
    endgenerate

    logic       dir_act;
    logic [1:0] dir_sel;

    always_comb begin
        dir_act = $onehot(filt[3:0]);
        dir_sel = 2'd0;
        if (filt[1])      dir_sel = 2'd1;
        else if (filt[2]) dir_sel = 2'd2;
        else if (filt[3]) dir_sel = 2'd3;
    end

    state_t           state_reg;
    logic [1:0]       lat_dir_reg;
    logic [CNT_W-1:0] rpt_cnt_reg;
    logic             push;
    logic [1:0]       push_dir;

    always_comb begin
        push     = 1'b0;
        push_dir = dir_sel;
        if (is_present && dir_act) begin
            if (state_reg == IDLE || dir_sel != lat_dir_reg) begin
                push = 1'b1;
            end else if (rpt_cnt_reg == CNT_W'(1)) begin
                push     = 1'b1;
                push_dir = lat_dir_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg   <= IDLE;
            lat_dir_reg <= 2'd0;
            rpt_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (dir_act) begin
                        lat_dir_reg <= dir_sel;
                        rpt_cnt_reg <= DELAY_LOAD;
                        state_reg   <= HOLD;
                    end
                end
                HOLD, REPEAT: begin
                    if (!dir_act) begin
                        state_reg <= IDLE;
                    end else if (dir_sel != lat_dir_reg) begin
                        lat_dir_reg <= dir_sel;
                        rpt_cnt_reg <= DELAY_LOAD;
                        state_reg   <= HOLD;
                    end else if (rpt_cnt_reg == CNT_W'(1)) begin
                        rpt_cnt_reg <= PERIOD_LOAD;
                        state_reg   <= REPEAT;
                    end else begin
                        rpt_cnt_reg <= rpt_cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    logic combo;
    logic combo_reg;
    logic restart_rise;
    logic restart_reg;

    assign combo        = filt[4] & filt[5];
    assign restart_rise = is_present && combo && !combo_reg;

    always_ff @(posedge clk) begin
        if (clear) begin
            combo_reg   <= 1'b0;
            restart_reg <= 1'b0;
        end else begin
            combo_reg   <= combo;
            restart_reg <= restart_rise;
        end
    end

    // Two-entry FIFO, entry 0 is always the head; restart flushes and beats a push.
    logic [1:0] fifo_mem_reg [2];
    logic [1:0] fifo_cnt_reg;
    logic       ovf_reg;
    logic       do_push;
    logic       pop;

    assign do_push = push && !restart_rise;
    assign pop     = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (clear || restart_rise) begin
            fifo_cnt_reg    <= 2'd0;
            fifo_mem_reg[0] <= 2'd0;
            fifo_mem_reg[1] <= 2'd0;
            ovf_reg         <= 1'b0;
        end else begin
            ovf_reg <= 1'b0;
            case ({do_push, pop})
                2'b10: begin
                    if (fifo_cnt_reg == 2'd2) begin
                        ovf_reg <= 1'b1;
                    end else begin
                        fifo_mem_reg[fifo_cnt_reg[0]] <= push_dir;
                        fifo_cnt_reg <= fifo_cnt_reg + 2'd1;
                    end
                end
                2'b01: begin
                    fifo_mem_reg[0] <= fifo_mem_reg[1];
                    fifo_cnt_reg    <= fifo_cnt_reg - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt_reg == 2'd1) begin
                        fifo_mem_reg[0] <= push_dir;
                    end else begin
                        fifo_mem_reg[0] <= fifo_mem_reg[1];
                        fifo_mem_reg[1] <= push_dir;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_valid    = (fifo_cnt_reg != 2'd0);
    assign cmd_dir      = fifo_mem_reg[0];
    assign restart      = restart_reg;
    assign cmd_overflow = ovf_reg;
endmodule
